// File: rtl/vga_num_display_if.sv
// vga_num_display_if: overlay bus (master drives frame_start/x/y/value; slave returns in_digit/digit_color/busy/overflow)
interface vga_num_display_if #(parameter int VALUE_W = 14);
  logic frame_start;
  logic [9:0] x;
  logic [9:0] y;
  logic [VALUE_W-1:0] value;
  logic in_digit;
  logic [23:0] digit_color;
  logic busy;
  logic overflow;
  modport master(output frame_start, x, y, value, input in_digit, digit_color, busy, overflow);
  modport slave(input frame_start, x, y, value, output in_digit, digit_color, busy, overflow);
endinterface

// File: rtl/vga_num_display.sv
// vga_num_display: seven-segment decimal overlay; clk, rst_n (async low), bus.slave (frame_start/x/y/value in, in_digit/digit_color/busy/overflow out)
module vga_num_display #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W = 14,
  parameter int BASE_X = 480,
  parameter int BASE_Y = 355,
  parameter int DIGIT_WIDTH = 30,
  parameter int DIGIT_HEIGHT = 40,
  parameter int DIGIT_SPACING = 35,
  parameter int SEG_T = 4,
  parameter int LZB = 1,
  parameter int FLASH_FRAMES = 8,
  parameter logic [23:0] ON_COLOR = 24'hFF0000,
  parameter logic [23:0] OFF_COLOR = 24'h006080,
  parameter logic [23:0] BG_COLOR = 24'h006080,
  parameter logic [23:0] FLASH_COLOR = 24'hFFFF00,
  parameter logic [23:0] OVF_COLOR = 24'hFF00FF
) (
  input logic clk,
  input logic rst_n,
  vga_num_display_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1) + 1;
  localparam int W = DIGIT_WIDTH;
  localparam int H = DIGIT_HEIGHT;
  localparam int T = SEG_T;
  localparam logic [63:0] MAXV = 64'(10 ** NUM_DIGITS - 1);
  localparam logic [DW-1:0] NINES = {NUM_DIGITS{4'h9}};
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  state_t state;
  logic [VALUE_W-1:0] sh, lat;
  logic [DW-1:0] bcd, adj, disp, nxt_disp;
  logic [CW-1:0] bit_cnt;
  logic [FW-1:0] flash_cnt;
  logic nxt_ovf, hit, run;
  logic [NUM_DIGITS-1:0] blank;
  logic [6:0] area, pat;
  logic [23:0] lit_color, color;
  int rx, ry;
  function automatic logic [6:0] seg_area(input int cx, input int cy);
    logic mx, rt, lf;
    mx = cx >= T && cx < W - T;
    rt = cx >= W - T;
    lf = cx < T;
    return {cy < T && mx,
            cy >= T && cy < H / 2 && rt,
            cy >= H / 2 && cy < H - T && rt,
            cy >= H - T && mx,
            cy >= H / 2 && cy < H - T && lf,
            cy >= T && cy < H / 2 && lf,
            cy >= H / 2 - T / 2 && cy < H / 2 + T / 2 && mx};
  endfunction
  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    nxt_ovf = 64'(lat) > MAXV;
    nxt_disp = nxt_ovf ? NINES : bcd;
  end
  always_comb begin
    run = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && disp[4*i+:4] == 4'd0;
      blank[i] = LZB != 0 && !bus.overflow && i > 0 && run;
    end
  end
  always_comb begin
    hit = 1'b0;
    area = '0;
    pat = '0;
    rx = 0;
    ry = int'(bus.y) - BASE_Y;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      rx = int'(bus.x) - (BASE_X + (NUM_DIGITS - 1 - i) * DIGIT_SPACING);
      if (ry >= 0 && ry < H && rx >= 0 && rx < W && !blank[i]) begin
        hit = 1'b1;
        area = seg_area(rx, ry);
        pat = seg_dec(disp[4*i+:4]);
      end
    end
    lit_color = bus.overflow ? OVF_COLOR : flash_cnt != '0 ? FLASH_COLOR : ON_COLOR;
    color = !hit ? BG_COLOR : (area & pat) != '0 ? lit_color : area != '0 ? OFF_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      lat <= '0;
      bcd <= '0;
      disp <= '0;
      bit_cnt <= '0;
      flash_cnt <= '0;
      bus.busy <= 1'b0;
      bus.overflow <= 1'b0;
      bus.in_digit <= 1'b0;
      bus.digit_color <= BG_COLOR;
    end else begin
      case (state)
        IDLE: if (bus.frame_start) begin
          sh <= bus.value;
          lat <= bus.value;
          bcd <= '0;
          bit_cnt <= CW'(VALUE_W);
          bus.busy <= 1'b1;
          state <= CONVERT;
        end
        CONVERT: begin
          bcd <= {adj[DW-2:0], sh[VALUE_W-1]};
          sh <= {sh[VALUE_W-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          disp <= nxt_disp;
          bus.overflow <= nxt_ovf;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      flash_cnt <= (state == COMMIT && (nxt_disp != disp || nxt_ovf != bus.overflow)) ? FW'(FLASH_FRAMES) :
                   (bus.frame_start && flash_cnt != '0) ? flash_cnt - 1'b1 : flash_cnt;
      bus.in_digit <= hit;
      bus.digit_color <= color;
    end
  end
endmodule

// File: tb/tb_vga_num_display.sv
// tb_vga_num_display: randomized self-checking bench against a decimal-arithmetic display model
module tb_vga_num_display;
  localparam int VW = 14;
  localparam logic [23:0] ON = 24'hFF0000, OFF = 24'h006080, BG = 24'h006080, FL = 24'hFFFF00, OV = 24'hFF00FF;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                          7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic clk = 0, rst_n = 0, fs = 0;
  logic [9:0] px = 0, py = 0;
  logic [VW-1:0] val = 0;
  int checks = 0, errors = 0;
  int m_shown = 0, m_ovf = 0, m_flash = 0;
  always #5 clk = ~clk;
  vga_num_display_if #(.VALUE_W(VW)) b0();
  vga_num_display_if #(.VALUE_W(VW)) b1();
  assign b0.frame_start = fs;
  assign b0.x = px;
  assign b0.y = py;
  assign b0.value = val;
  assign b1.frame_start = fs;
  assign b1.x = px;
  assign b1.y = py;
  assign b1.value = val;
  vga_num_display #(.LZB(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  vga_num_display #(.LZB(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  function automatic void exp_pix(input int x, input int y, input int lzb, output logic ind, output logic [23:0] col);
    int rx, ry, d, seg;
    logic [6:0] p;
    ind = 0;
    col = BG;
    for (int i = 0; i < 4; i++) begin
      rx = x - (480 + (3 - i) * 35);
      ry = y - 355;
      if (rx >= 0 && rx < 30 && ry >= 0 && ry < 40 && !(lzb != 0 && m_ovf == 0 && i > 0 && m_shown < 10 ** i)) begin
        d = (m_shown / (10 ** i)) % 10;
        p = SEG_TAB[d];
        seg = -1;
        if (ry < 4 && rx >= 4 && rx < 26) seg = 0;
        else if (ry >= 4 && ry < 20 && rx >= 26) seg = 1;
        else if (ry >= 20 && ry < 36 && rx >= 26) seg = 2;
        else if (ry >= 36 && rx >= 4 && rx < 26) seg = 3;
        else if (ry >= 20 && ry < 36 && rx < 4) seg = 4;
        else if (ry >= 4 && ry < 20 && rx < 4) seg = 5;
        else if (ry >= 18 && ry < 22 && rx >= 4 && rx < 26) seg = 6;
        ind = 1;
        col = seg < 0 ? BG : !p[6-seg] ? OFF : m_ovf != 0 ? OV : m_flash != 0 ? FL : ON;
      end
    end
  endfunction
  task automatic check_pix(input int x, input int y);
    logic e0, e1;
    logic [23:0] c0, c1;
    @(negedge clk);
    px = 10'(x);
    py = 10'(y);
    @(posedge clk);
    #1;
    exp_pix(x, y, 1, e0, c0);
    exp_pix(x, y, 0, e1, c1);
    checks += 4;
    if (b0.in_digit !== e0) begin errors++; $display("FAIL in_digit lzb1 (%0d,%0d): got %b want %b", x, y, b0.in_digit, e0); end
    if (b0.digit_color !== c0) begin errors++; $display("FAIL color lzb1 (%0d,%0d): got %h want %h", x, y, b0.digit_color, c0); end
    if (b1.in_digit !== e1) begin errors++; $display("FAIL in_digit lzb0 (%0d,%0d): got %b want %b", x, y, b1.in_digit, e1); end
    if (b1.digit_color !== c1) begin errors++; $display("FAIL color lzb0 (%0d,%0d): got %h want %h", x, y, b1.digit_color, c1); end
  endtask
  task automatic rand_pix(input int n);
    for (int k = 0; k < n; k++) check_pix($urandom_range(470, 630), $urandom_range(345, 405));
  endtask
  task automatic run_frame(input int v, input int inj);
    int n, nov, nsh;
    @(negedge clk);
    val = VW'(v);
    fs = 1;
    @(posedge clk);
    #1 fs = 0;
    if (m_flash > 0) m_flash--;
    n = 0;
    while (b0.busy === 1'b1 && n < 100) begin
      n++;
      fs = (n == inj);
      if (n == inj && m_flash > 0) m_flash--;
      @(posedge clk);
      #1;
    end
    fs = 0;
    nov = v > 9999 ? 1 : 0;
    nsh = nov != 0 ? 9999 : v;
    if (nsh != m_shown || nov != m_ovf) m_flash = 8;
    m_shown = nsh;
    m_ovf = nov;
    checks += 2;
    if (n != VW + 1) begin errors++; $display("FAIL busy_len value=%0d: got %0d want %0d", v, n, VW + 1); end
    if (b0.overflow !== 1'(nov)) begin errors++; $display("FAIL overflow value=%0d: got %b want %0d", v, b0.overflow, nov); end
  endtask
  task automatic test_reset;
    rst_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      px = 10'($urandom_range(470, 630));
      py = 10'($urandom_range(345, 405));
      @(posedge clk);
      #1;
      checks += 4;
      if (b0.in_digit !== 1'b0) begin errors++; $display("FAIL reset in_digit: got %b want 0", b0.in_digit); end
      if (b0.digit_color !== BG) begin errors++; $display("FAIL reset color: got %h want %h", b0.digit_color, BG); end
      if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", b0.busy); end
      if (b0.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", b0.overflow); end
    end
    @(negedge clk);
    rst_n = 1;
    check_pix(595, 356);
    check_pix(585, 356);
    check_pix(490, 370);
  endtask
  task automatic test_convert;
    run_frame(123, 0);
    for (int k = 0; k < 8; k++) run_frame(123, 0);
    check_pix(490, 356);
    check_pix(543, 365);
    check_pix(525, 356);
    rand_pix(10);
  endtask
  task automatic test_overflow;
    run_frame(10000, 0);
    check_pix(490, 356);
    check_pix(490, 375);
    rand_pix(8);
  endtask
  task automatic test_flash;
    run_frame(123, 0);
    run_frame(124, 0);
    for (int k = 0; k < 9; k++) begin
      check_pix(613, 365);
      run_frame(124, 0);
    end
    check_pix(613, 365);
    run_frame(124, 0);
    check_pix(613, 365);
  endtask
  task automatic test_ignore;
    run_frame(4321, 5);
    rand_pix(4);
  endtask
  task automatic test_reset_mid;
    run_frame(8765, 0);
    @(negedge clk);
    val = VW'(55);
    fs = 1;
    @(posedge clk);
    #1 fs = 0;
    repeat (6) @(posedge clk);
    #3 rst_n = 0;
    #1;
    m_shown = 0;
    m_ovf = 0;
    m_flash = 0;
    checks += 3;
    if (b0.busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", b0.busy); end
    if (b0.in_digit !== 1'b0) begin errors++; $display("FAIL midreset in_digit: got %b want 0", b0.in_digit); end
    if (b0.digit_color !== BG) begin errors++; $display("FAIL midreset color: got %h want %h", b0.digit_color, BG); end
    @(negedge clk);
    rst_n = 1;
    check_pix(600, 356);
    check_pix(565, 356);
  endtask
  task automatic test_zero;
    run_frame(0, 0);
    check_pix(490, 356);
    check_pix(500, 356);
    check_pix(533, 380);
    check_pix(600, 393);
  endtask
  task automatic test_random;
    for (int k = 0; k < 15; k++) begin
      run_frame(k % 4 == 0 ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 9999)), 0);
      rand_pix(6);
    end
  endtask
  initial begin
    test_reset;
    test_convert;
    test_overflow;
    test_flash;
    test_ignore;
    test_reset_mid;
    test_zero;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
